ifu_fetch: RTL and testbench

- Instruction fetch unit. Owns the PC, issues word reads to instruction memory, and delivers (pc, inst) pairs to the decode/sim stage over a valid/ready handshake.
- Detects EBREAK (32'h0010_0073) on its own output, stops fetching after that instruction is delivered, and raises `halt` so the harness can end simulation.
- Supports a redirect from execute (branch, jump or trap) that flushes everything in flight.

---
 rtl/ifu_fetch.sv | 198 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads to instruction memory and hands
// (pc, inst) pairs downstream; halts on a delivered EBREAK. Define IFU_TRACE_EN for a text trace.
module ifu_fetch #(
   parameter int unsigned     XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            halt
);

   localparam int unsigned   PW     = $clog2(BUF_DEPTH);
   localparam int unsigned   CW     = PW + 1;
   localparam logic [CW-1:0] DEPTH  = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
   localparam logic [31:0]   EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t          state_r;
   logic [XLEN-1:0] pc_r;
   logic [CW-1:0]   outs_r;
   logic [CW-1:0]   drop_r;
   logic [CW-1:0]   count_r;
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [XLEN-1:0] buf_pc_r   [BUF_DEPTH];
   logic [31:0]     buf_inst_r [BUF_DEPTH];
   logic [XLEN-1:0] out_pc_r;
   logic [31:0]     out_inst_r;
   logic            halt_r;

   logic            req_valid_s;
   logic            pop_s;
   logic            ebreak_s;
   logic            redir_s;
   logic            clear_s;
   logic            hs_s;
   logic            take_s;
   logic            drop_s;
   logic            push_s;
   logic            head_load_s;
   logic [CW-1:0]   inflight_s;
   logic [CW-1:0]   credit_s;
   logic [CW-1:0]   cnt_after_pop_s;
   logic [CW-1:0]   count_next_s;
   logic [CW:0]     occupied_next_s;
   logic [PW-1:0]   head_next_s;
   logic [XLEN-1:0] resp_pc_s;
   logic [XLEN-1:0] head_pc_s;
   logic [31:0]     head_inst_s;
   logic            unused_s;

   // Handshake decode, request credit and next head-of-buffer selection.
   always_comb begin
      pop_s      = (count_r != ZERO) & out_ready;
      ebreak_s   = pop_s & (out_inst_r == EBREAK);
      redir_s    = redirect_valid & (state_r != HALT) & ~ebreak_s;
      clear_s    = ebreak_s | redir_s;
      inflight_s = outs_r + drop_r;
      // A slot emptied by this cycle's transfer already counts as free.
      credit_s    = (DEPTH - count_r) + CW'(pop_s);
      req_valid_s = ~rst & (state_r == FETCH) & (credit_s > inflight_s);
      hs_s        = req_valid_s & imem_req_ready;
      drop_s      = imem_resp_valid & (drop_r != ZERO);
      take_s      = imem_resp_valid & (drop_r == ZERO);
      push_s      = take_s & (state_r != HALT) & ~clear_s;
      // Oldest live request sits outs_r words behind the next fetch address.
      resp_pc_s       = pc_r - XLEN'({outs_r, 2'b00});
      cnt_after_pop_s = count_r - CW'(pop_s);
      count_next_s    = cnt_after_pop_s + CW'(push_s);
      head_next_s     = head_r + PW'(pop_s);
      head_load_s     = ~clear_s & (count_next_s != ZERO);
      if (cnt_after_pop_s == ZERO) begin
         head_pc_s   = resp_pc_s;
         head_inst_s = imem_resp_data;
      end else begin
         head_pc_s   = buf_pc_r[head_next_s];
         head_inst_s = buf_inst_r[head_next_s];
      end
      occupied_next_s = {1'b0, cnt_after_pop_s} + {1'b0, inflight_s} - {{CW{1'b0}}, drop_s};
   end

   // Fetch FSM, PC, in-flight bookkeeping and output buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= FETCH;
         pc_r       <= RESET_PC;
         outs_r     <= ZERO;
         drop_r     <= ZERO;
         count_r    <= ZERO;
         head_r     <= {PW{1'b0}};
         tail_r     <= {PW{1'b0}};
         out_pc_r   <= {XLEN{1'b0}};
         out_inst_r <= 32'h0000_0000;
         halt_r     <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_pc_r[i]   <= {XLEN{1'b0}};
            buf_inst_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (redir_s) begin
            pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
         end else if (hs_s) begin
            pc_r <= pc_r + {{(XLEN-3){1'b0}}, 3'b100};
         end

         if (ebreak_s || (state_r == HALT)) begin
            outs_r <= ZERO;
            drop_r <= ZERO;
         end else if (redir_s) begin
            // Everything still in flight, including a request accepted now, is stale.
            outs_r <= ZERO;
            drop_r <= inflight_s + CW'(hs_s) - CW'(imem_resp_valid);
         end else begin
            outs_r <= outs_r + CW'(hs_s) - CW'(take_s);
            drop_r <= drop_r - CW'(drop_s);
         end

         if (push_s) begin
            buf_pc_r[tail_r]   <= resp_pc_s;
            buf_inst_r[tail_r] <= imem_resp_data;
         end
         if (clear_s) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= ZERO;
         end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_r + PW'(push_s);
            count_r <= count_next_s;
         end
         if (head_load_s) begin
            out_pc_r   <= head_pc_s;
            out_inst_r <= head_inst_s;
         end

         if (ebreak_s) begin
            halt_r <= 1'b1;
         end

         if (ebreak_s) begin
            state_r <= HALT;
         end else if (redir_s) begin
            state_r <= FETCH;
         end else begin
            case (state_r)
               FETCH:   state_r <= req_valid_s ? FETCH : WAIT;
               WAIT:    state_r <= (occupied_next_s < {1'b0, DEPTH}) ? FETCH : WAIT;
               HALT:    state_r <= HALT;
               default: state_r <= FETCH;
            endcase
         end
      end
   end

`ifdef IFU_TRACE_EN
   // Text trace of deliveries, redirects and the halting EBREAK.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (pop_s) begin
            $display("[IFU] pc=%016h inst=%08h", out_pc_r, out_inst_r);
         end
         if (redir_s) begin
            $display("[IFU] redirect -> %016h", {redirect_pc[XLEN-1:2], 2'b00});
         end
         if (ebreak_s) begin
            $display("[IFU] EBREAK at %016h, halting", out_pc_r);
         end
      end
   end
`endif

   assign unused_s       = ^redirect_pc[1:0];
   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = pc_r;
   assign out_valid      = (count_r != ZERO);
   assign out_pc         = out_pc_r;
   assign out_inst       = out_inst_r;
   assign halt           = halt_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: in-order PC model plus directed literal checks.
module tb_ifu_fetch;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic        halt;

   logic        w_rst, w_req_valid, w_req_ready, w_resp_valid, w_redirect_valid;
   logic        w_out_valid, w_out_ready, w_halt;
   logic [63:0] w_req_addr, w_redirect_pc, w_out_pc;
   logic [31:0] w_resp_data, w_out_inst;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        mem_hold;
   logic [63:0] ebreak_addr;
   logic [63:0] pend[$];
   logic [63:0] exp_pc, prev_pc, prev_addr;
   logic [31:0] prev_inst;
   logic        exp_halt, prev_stall, prev_req_wait;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .halt(halt)
   );

   ifu_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
      .clk(clk), .rst(w_rst),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
      .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_inst(w_out_inst),
      .halt(w_halt)
   );

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == ebreak_addr) return EBREAK;
      else return 32'h0000_0013 ^ {a[23:0], 8'h00};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model and per-cycle scoreboard: delivered PCs must run in order from the last restart.
   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend.delete();
            exp_pc        = RESET_PC;
            exp_halt      = 1'b0;
            prev_stall    = 1'b0;
            prev_req_wait = 1'b0;
         end else begin
            chk("m_halt", halt, exp_halt);
            if (exp_halt) begin
               chk("m_halt_idle", out_valid, 64'd0);
               chk("m_halt_noreq", imem_req_valid, 64'd0);
            end
            if (out_valid) begin
               chk("m_pc", out_pc, exp_pc);
               chk("m_inst", out_inst, mem_word(exp_pc));
            end
            if (prev_stall) begin
               chk("m_hold_valid", out_valid, 64'd1);
               chk("m_hold_pc", out_pc, prev_pc);
               chk("m_hold_inst", out_inst, prev_inst);
            end
            if (prev_req_wait && imem_req_valid) chk("m_addr_hold", imem_req_addr, prev_addr);
            if (imem_req_valid) chk("m_addr_align", imem_req_addr[1:0], 64'd0);
            prev_stall    = out_valid && !out_ready && !redirect_valid;
            prev_pc       = out_pc;
            prev_inst     = out_inst;
            prev_req_wait = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr     = imem_req_addr;
            if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
            if (out_valid && out_ready) begin
               if (mem_word(exp_pc) == EBREAK) exp_halt = 1'b1;
               exp_pc = exp_pc + 64'd4;
            end
            if (redirect_valid && !exp_halt) exp_pc = {redirect_pc[63:2], 2'b00};
         end
         @(posedge clk);
         #1;
         if (!mem_hold && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; out_ready = 1'b1; imem_req_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 64'd0; mem_hold = 1'b0; ebreak_addr = 64'd1;
      w_rst = 1'b1; w_req_ready = 1'b1; w_resp_valid = 1'b0; w_resp_data = 32'h0;
      w_redirect_valid = 1'b0; w_redirect_pc = 64'd0; w_out_ready = 1'b1;
      tick(); tick();

      // Reset values
      chk("rst_req_valid", imem_req_valid, 64'd0);
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_halt", halt, 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_inst", out_inst, 64'd0);
      chk("rst_addr", imem_req_addr, RESET_PC);
      chk("wrap_rst_addr", w_req_addr, WRAP_PC);

      // Free run with 1-cycle memory; wrap DUT fetches across zero
      rst = 1'b0; w_rst = 1'b0;
      tick();
      chk("lat_no_valid", out_valid, 64'd0);
      chk("wrap_second_addr", w_req_addr, 64'd0);
      chk("wrap_second_valid", w_req_valid, 64'd1);
      tick();
      chk("lat_first_valid", out_valid, 64'd1);
      chk("lat_first_pc", out_pc, 64'h0000_0000_8000_0000);
      chk("lat_first_inst", out_inst, 64'h0000_0013);
      tick();
      chk("run_pc1", out_pc, 64'h0000_0000_8000_0004);
      chk("run_inst1", out_inst, 64'h0000_0413);
      tick();
      chk("run_pc2", out_pc, 64'h0000_0000_8000_0008);
      imem_req_ready = 1'b0;
      repeat (3) tick();
      imem_req_ready = 1'b1;
      repeat (8) tick();
      chk("run_no_halt", halt, 64'd0);

      // Backpressure from reset
      rst = 1'b1; tick(); tick();
      rst = 1'b0; out_ready = 1'b0;
      repeat (12) tick();
      chk("bp_valid", out_valid, 64'd1);
      chk("bp_pc", out_pc, 64'h0000_0000_8000_0000);
      chk("bp_req_off", imem_req_valid, 64'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_resume_pc", out_pc, 64'h0000_0000_8000_0004);
      repeat (8) tick();

      // EBREAK at 0x8000_0008, with a redirect in the same cycle as its transfer
      ebreak_addr = 64'h0000_0000_8000_0008;
      rst = 1'b1; tick(); tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("eb_head_pc", out_pc, 64'h0000_0000_8000_0008);
      chk("eb_head_inst", out_inst, 64'h0010_0073);
      redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0200;
      tick();
      redirect_valid = 1'b0;
      chk("eb_halt", halt, 64'd1);
      chk("eb_out_off", out_valid, 64'd0);
      chk("eb_req_off", imem_req_valid, 64'd0);
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      repeat (5) tick();
      chk("eb_halt_sticky", halt, 64'd1);
      chk("eb_still_idle", out_valid, 64'd0);
      chk("eb_still_noreq", imem_req_valid, 64'd0);
      ebreak_addr = 64'd1;

      // Redirect with two requests in flight
      rst = 1'b1; mem_hold = 1'b1; tick(); tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("rd_full_noreq", imem_req_valid, 64'd0);
      redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0103;
      tick();
      redirect_valid = 1'b0; mem_hold = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      chk("rd_valid", out_valid, 64'd1);
      chk("rd_pc", out_pc, 64'h0000_0000_8000_0100);
      chk("rd_inst", out_inst, 64'h0001_0013);
      repeat (6) tick();

      // Reset while stalled with a request outstanding
      rst = 1'b1; tick(); tick();
      rst = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("ms_valid", out_valid, 64'd1);
      rst = 1'b1;
      tick();
      chk("ms_rst_valid", out_valid, 64'd0);
      chk("ms_rst_req", imem_req_valid, 64'd0);
      chk("ms_rst_pc", out_pc, 64'd0);
      chk("ms_rst_inst", out_inst, 64'd0);
      chk("ms_rst_addr", imem_req_addr, RESET_PC);
      rst = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("ms_restart_valid", out_valid, 64'd1);
      chk("ms_restart_pc", out_pc, 64'h0000_0000_8000_0000);
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
